decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   Registered, parametrised RV32-format decode stage between fetch and execute.
//   - Splits each accepted instruction into fields.
//   - Selects the immediate for the opcode's format and sign-extends it to XLEN.
//   - Flags illegal encodings.
//   - Carries PC alongside the instruction.
//   - valid/ready on both sides; internal 2-entry skid buffer, so back-pressure
//     never drops an instruction and in_ready depends on registered state only.
// PARAMETERS
//   XLEN     32  datapath width of out_imm/in_pc/out_pc; legal values 32 or 64
//   CHK_ILL  1   1: illegal detection enabled; 0: out_illegal tied to 0
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   flush        in   1      synchronous kill of all buffered instructions
//   in_valid     in   1      in_instr/in_pc valid
//   in_ready     out  1      stage can accept; transfer when in_valid & in_ready
//   in_instr     in   32     raw instruction word
//   in_pc        in   XLEN   PC of in_instr
//   out_valid    out  1      decoded instruction present
//   out_ready    in   1      consumer accepts; transfer when out_valid & out_ready
//   out_opcode   out  7      instr[6:0]
//   out_rd       out  5      instr[11:7]
//   out_funct3   out  3      instr[14:12]
//   out_rs1      out  5      instr[19:15]
//   out_rs2      out  5      instr[24:20]
//   out_funct7   out  7      instr[31:25]
//   out_imm      out  XLEN   selected immediate, sign-extended to XLEN
//   out_fmt      out  3      0=R 1=I 2=S 3=B 4=U 5=J
//   out_illegal  out  1      encoding not supported
//   out_pc       out  XLEN   PC of the decoded instruction
// BEHAVIOUR
//   Reset (rst_n low, async): every output 0, except in_ready which is 1.
//     Both buffer entries empty.
//   Decode is combinational on in_instr. The result is stored in the buffer.
//   Latency: accept in cycle N -> out_valid in cycle N+1 (output buffer empty).
//   Buffer: main entry M drives out_*; skid entry S holds overflow.
//     in_ready = ~S.valid (registered).
//     Accept while M empty or M leaving -> write M.
//     Accept while M held (out_valid & ~out_ready) -> write S.
//     M leaves with S valid -> S moves to M; S empties; in_ready is 1 next cycle.
//     Instruction order is preserved. Throughput is 1/cycle when out_ready=1.
//     out_* stay stable while out_valid & ~out_ready.
//   Format / immediate select by opcode (instr[6:0]):
//     0110111 LUI, 0010111 AUIPC -> U: {instr[31:12],12'b0}, sign-extended from bit 31
//     1101111 JAL   -> J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
//     1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM,
//       1110011 SYSTEM -> I: instr[31:20]
//     0100011 STORE  -> S: {instr[31:25],instr[11:7]}
//     1100011 BRANCH -> B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
//     0110011 OP     -> R: out_imm = 0
//     All sign extension is from instr[31] to full XLEN.
//   Illegal (CHK_ILL=1); any of the following:
//     - opcode not in the list above (covers instr[1:0] != 2'b11)
//     - JALR with funct3 != 0
//     - BRANCH with funct3 = 010 or 011
//     - OP with funct7 not in {0000000, 0100000}
//     - OP with funct7 = 0100000 and funct3 not in {000, 101}
//   An illegal instruction is still passed through: fmt=R, imm=0, out_illegal=1.
//   flush: next cycle M and S are empty, out_valid=0, in_ready=1.
//     flush beats a same-cycle accept; that instruction is dropped.
//     An out transfer in the flush cycle still completes.
//   Reset asserted mid-operation: immediate return to the reset state.
//     Buffered instructions are lost.
// TESTING
//   1. in 0x00500093 (addi x1,x0,5), pc 0x100, out_ready=1 -> next cycle:
//      opcode 0x13, rd=1, fmt=I, imm=5, pc 0x100, illegal=0.
//   2. in 0xFE000EE3 (beq x0,x0,-4) -> fmt=B, imm=0xFFFFFFFC;
//      with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
//   3. out_ready=0, push 3 instrs -> first two accepted; in_ready=0 after the second.
//      Raise out_ready -> all three come out in order, no loss or duplication.
//   4. in 0xFFFFFFFF, then 0x0000706B -> both out_illegal=1, imm=0, fmt=R.
//      Same words with CHK_ILL=0 -> out_illegal=0.
//   5. Two instructions buffered, flush together with in_valid -> next cycle
//      out_valid=0, in_ready=1; the offered instruction never appears.
//   6. rst_n low while out_valid=1 -> all outputs 0 at once, in_ready=1.
//      After release, the first accept appears after 1 cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32-format decode stage: field split, immediate select/sign-extend, illegal check.
// Results are registered into a 2-entry skid buffer (main + overflow) with valid/ready on both sides.
module decode_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CHK_ILL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;

  entry_t      dec;
  logic [31:0] imm32;
  logic [2:0]  fmt;
  logic        known;
  logic        bad;
  logic        ill;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    imm32 = '0;
    fmt   = FmtR;
    known = 1'b1;
    bad   = 1'b0;
    case (in_instr[6:0])
      OpLui, OpAuipc: begin
        fmt   = FmtU;
        imm32 = {in_instr[31:12], 12'b0};
      end
      OpJal: begin
        fmt   = FmtJ;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      OpJalr: begin
        fmt   = FmtI;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        bad   = (f3 != 3'b000);
      end
      OpLoad, OpImm, OpMisc, OpSystem: begin
        fmt   = FmtI;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpStore: begin
        fmt   = FmtS;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OpBranch: begin
        fmt   = FmtB;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
        bad   = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OpOp: begin
        fmt = FmtR;
        bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000)) ||
              ((f7 == 7'b0100000) && !((f3 == 3'b000) || (f3 == 3'b101)));
      end
      default: known = 1'b0;
    endcase

    ill       = (CHK_ILL != 0) && (!known || bad);
    dec.instr = in_instr;
    dec.pc    = in_pc;
    dec.ill   = ill;
    // Illegal words pass through as R-format with a zero immediate.
    dec.fmt   = ill ? FmtR : fmt;
    dec.imm   = ill ? '0 : XLEN'($signed(imm32));
  end

  entry_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   accept, m_free;

  assign in_ready = ~s_valid_q;
  assign accept   = in_valid & ~s_valid_q;
  assign m_free   = ~m_valid_q | out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      // The skid entry is older than anything on the input, so it refills M first.
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = accept;
        if (accept) m_d = dec;
      end
    end else if (accept) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_valid   = m_valid_q;
  assign out_opcode  = m_q.instr[6:0];
  assign out_rd      = m_q.instr[11:7];
  assign out_funct3  = m_q.instr[14:12];
  assign out_rs1     = m_q.instr[19:15];
  assign out_rs2     = m_q.instr[24:20];
  assign out_funct7  = m_q.instr[31:25];
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.ill;
  assign out_pc      = m_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table pushed through a scoreboard, plus buffer/flush/reset
// sequences. A second instance (XLEN=64, CHK_ILL=0) shares the inputs.
module tb_decode_stage;

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;
  localparam int NV = 23;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready, o_valid, o_ill;
  logic [6:0]  o_opcode, o_funct7;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_funct3, o_fmt;
  logic [31:0] o_imm, o_pc;

  logic        w_in_ready, w_valid, w_ill;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3, w_fmt;
  logic [63:0] w_imm, w_pc;

  vec_t        vecs [NV];
  exp_t        sbq [$];
  exp_t        drv_exp;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic        rand_rdy = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CHK_ILL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(o_valid), .out_ready(out_ready),
    .out_opcode(o_opcode), .out_rd(o_rd), .out_funct3(o_funct3), .out_rs1(o_rs1),
    .out_rs2(o_rs2), .out_funct7(o_funct7), .out_imm(o_imm), .out_fmt(o_fmt),
    .out_illegal(o_ill), .out_pc(o_pc)
  );

  decode_stage #(.XLEN(64), .CHK_ILL(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(w_valid), .out_ready(out_ready),
    .out_opcode(w_opcode), .out_rd(w_rd), .out_funct3(w_funct3), .out_rs1(w_rs1),
    .out_rs2(w_rs2), .out_funct7(w_funct7), .out_imm(w_imm), .out_fmt(w_fmt),
    .out_illegal(w_ill), .out_pc(w_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_input(input int i);
    in_instr = vecs[i].instr;
    in_pc    = 64'h1_0000_0100 + 64'(4 * i);
    drv_exp  = '{vecs[i].instr, in_pc, vecs[i].fmt, vecs[i].imm, vecs[i].ill};
  endtask

  task automatic send(input int i);
    logic ok;
    ok = 1'b0;
    set_input(i);
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (sbq.size() == 0 && !o_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    chk("drain_valid", 64'(o_valid), 64'd0);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_fields", 64'({o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode}), 64'd0);
    chk("rst_imm", 64'(o_imm), 64'd0);
    chk("rst_fmt", 64'(o_fmt), 64'd0);
    chk("rst_ill", 64'(o_ill), 64'd0);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst64_valid", 64'(w_valid), 64'd0);
    chk("rst64_imm", w_imm, 64'd0);
    chk("rst64_pc", w_pc, 64'd0);
  endtask

  // Monitor: transfers are decided at the next rising edge, so judge them at the falling edge.
  initial begin
    logic        prev_hold;
    logic [31:0] prev_instr, cur_instr;
    logic [31:0] prev_pc;
    exp_t        e;
    prev_hold  = 1'b0;
    prev_instr = '0;
    prev_pc    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        cur_instr = {o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode};
        if (prev_hold) begin
          chk("stall_valid", 64'(o_valid), 64'd1);
          chk("stall_instr", 64'(cur_instr), 64'(prev_instr));
          chk("stall_pc", 64'(o_pc), 64'(prev_pc));
        end
        if (o_valid && out_ready) begin
          n_out++;
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got instr %h, expected none", cur_instr);
          end else begin
            e = sbq.pop_front();
            chk("out_instr", 64'(cur_instr), 64'(e.instr));
            chk("out_pc", 64'(o_pc), 64'(e.pc[31:0]));
            chk("out_fmt", 64'(o_fmt), 64'(e.fmt));
            chk("out_imm", 64'(o_imm), 64'(e.imm[31:0]));
            chk("out_illegal", 64'(o_ill), 64'(e.ill));
            chk("x64_valid", 64'(w_valid), 64'd1);
            chk("x64_instr", 64'({w_funct7, w_rs2, w_rs1, w_funct3, w_rd, w_opcode}),
                64'(e.instr));
            chk("x64_pc", w_pc, e.pc);
            chk("x64_illegal", 64'(w_ill), 64'd0);
            if (!e.ill) chk("x64_imm", w_imm, e.imm);
          end
        end
        prev_hold  = o_valid && !out_ready && !flush;
        prev_instr = cur_instr;
        prev_pc    = o_pc;
        if (flush) sbq.delete();
        else if (in_valid && in_ready) sbq.push_back(drv_exp);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    drv_exp = '{32'd0, 64'd0, 3'd0, 64'd0, 1'b0};

    vecs[0]  = '{32'h00500093, FmtI, 64'd5, 1'b0};
    vecs[1]  = '{32'hFE000EE3, FmtB, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[2]  = '{32'h123450B7, FmtU, 64'h0000_0000_1234_5000, 1'b0};
    vecs[3]  = '{32'h80000117, FmtU, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[4]  = '{32'h0080006F, FmtJ, 64'd8, 1'b0};
    vecs[5]  = '{32'hFFDFF06F, FmtJ, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[6]  = '{32'hFE20AC23, FmtS, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
    vecs[7]  = '{32'h002081B3, FmtR, 64'd0, 1'b0};
    vecs[8]  = '{32'h402081B3, FmtR, 64'd0, 1'b0};
    vecs[9]  = '{32'h402091B3, FmtR, 64'd0, 1'b1};
    vecs[10] = '{32'h022081B3, FmtR, 64'd0, 1'b1};
    vecs[11] = '{32'hFFF100E7, FmtI, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[12] = '{32'hFFF110E7, FmtR, 64'd0, 1'b1};
    vecs[13] = '{32'hFE002EE3, FmtR, 64'd0, 1'b1};
    vecs[14] = '{32'h7FF02283, FmtI, 64'd2047, 1'b0};
    vecs[15] = '{32'hFFFFFFFF, FmtR, 64'd0, 1'b1};
    vecs[16] = '{32'h0000706B, FmtR, 64'd0, 1'b1};
    vecs[17] = '{32'h00000073, FmtI, 64'd0, 1'b0};
    vecs[18] = '{32'h0FF0000F, FmtI, 64'h0FF, 1'b0};
    vecs[19] = '{32'h00209863, FmtB, 64'd16, 1'b0};
    vecs[20] = '{32'h00000012, FmtR, 64'd0, 1'b1};
    vecs[21] = '{32'h4020D1B3, FmtR, 64'd0, 1'b0};
    vecs[22] = '{32'h0000106F, FmtJ, 64'h0000_0000_0000_1000, 1'b0};

    #12;
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full-rate stream, then random back-pressure.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(i);
    drain();
    rand_rdy = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NV; i++) send(i);
    drain();

    // Stalled output: two accepted, third waits until space opens.
    base = n_out;
    out_ready = 1'b0;
    set_input(2); in_valid = 1'b1;
    @(negedge clk); chk("t3_rdy_a", 64'(in_ready), 64'd1);
    @(posedge clk); #1; set_input(3);
    @(negedge clk); chk("t3_rdy_b", 64'(in_ready), 64'd1);
    @(posedge clk); #1; set_input(4);
    @(negedge clk); chk("t3_rdy_full", 64'(in_ready), 64'd0);
    chk("t3_head_pc", 64'(o_pc), 64'h108);
    @(posedge clk); #1;
    @(negedge clk); chk("t3_rdy_hold", 64'(in_ready), 64'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1; in_valid = 1'b0;
    drain();
    chk("t3_count", 64'(n_out - base), 64'd3);

    // Flush beats a same-cycle accept with only M occupied.
    out_ready = 1'b0;
    send(5);
    set_input(6); in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    chk("t5a_valid", 64'(o_valid), 64'd0);
    chk("t5a_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t5a_quiet", 64'(o_valid), 64'd0);

    // Flush with both entries full and an instruction offered.
    out_ready = 1'b0;
    send(7);
    send(8);
    set_input(9); in_valid = 1'b1; flush = 1'b1;
    @(negedge clk); chk("t5b_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    chk("t5b_valid", 64'(o_valid), 64'd0);
    chk("t5b_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t5b_quiet", 64'(o_valid), 64'd0);

    // Output transfer in the flush cycle still completes.
    set_input(10); in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b1; base = n_out;
    @(posedge clk); #1; flush = 1'b0;
    chk("t5c_out_done", 64'(n_out - base), 64'd1);
    chk("t5c_valid", 64'(o_valid), 64'd0);

    // Asynchronous reset mid-operation, then single-cycle latency after release.
    out_ready = 1'b0;
    send(11);
    send(12);
    chk("t6_pre_valid", 64'(o_valid), 64'd1);
    #2; rst_n = 1'b0;
    #1; chk_reset();
    sbq.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    out_ready = 1'b1;
    set_input(1); in_valid = 1'b1;
    @(negedge clk);
    chk("t6_rdy", 64'(in_ready), 64'd1);
    chk("t6_empty", 64'(o_valid), 64'd0);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("t6_latency", 64'(o_valid), 64'd1);
    drain();

    chk("sb_final", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
